// File: rtl/mulacc_wide_cxu.sv
// Stateful multiply-accumulate CXU (CXU-L1): per-context 2*DATA_W accumulators, fixed-latency pipeline.
// Optional saturating mulacc/mulsub with a sticky status flag: define MULACC_WIDE_CXU_SAT_EN.
module mulacc_wide_cxu #(
  parameter int  CXU_N_CXUS     = 1,
  parameter int  CXU_N_STATES   = 4,
  parameter int  CXU_LATENCY    = 2,
  parameter int  CXU_RESET      = 0,
  parameter int  CXU_FUNC_ID_W  = 10,
  parameter int  CXU_DATA_W     = 32,
  localparam int CXU_CXU_ID_W   = (CXU_N_CXUS > 1) ? $clog2(CXU_N_CXUS) : 1,
  localparam int CXU_STATE_ID_W = $clog2(CXU_N_STATES) + 1,
  localparam int CXU_STATUS_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic                      req_valid,
  input  logic [CXU_CXU_ID_W-1:0]   req_cxu,
  input  logic [CXU_STATE_ID_W-1:0] req_state,
  input  logic [CXU_FUNC_ID_W-1:0]  req_func,
  input  logic [CXU_DATA_W-1:0]     req_data0,
  input  logic [CXU_DATA_W-1:0]     req_data1,
  output logic                      resp_valid,
  output logic [CXU_STATUS_W-1:0]   resp_status,
  output logic [CXU_DATA_W-1:0]     resp_data
);
  localparam int DW     = CXU_DATA_W;
  localparam int AW     = 2 * CXU_DATA_W;
  localparam int SIDX_W = (CXU_N_STATES > 1) ? $clog2(CXU_N_STATES) : 1;

  typedef logic [9:0] cfid_t;
  typedef enum logic [CXU_STATUS_W-1:0] {
    CXU_OK = 3'd0, CXU_ERROR_FUNC = 3'd1, CXU_ERROR_STATE = 3'd2, CXU_ERROR_OFF = 3'd3
  } cxu_status_t;
  typedef enum logic [1:0] {CS_OFF = 2'd0, CS_INIT = 2'd1, CS_CLEAN = 2'd2, CS_DIRTY = 2'd3} cs_e;

  localparam cfid_t F_MUL       = 10'd0;
  localparam cfid_t F_MULACC    = 10'd1;
  localparam cfid_t F_MULSUB    = 10'd2;
  localparam cfid_t F_RD_HI     = 10'd3;
  localparam cfid_t F_CLEAR     = 10'd4;
  localparam cfid_t F_WR_STATE  = 10'd1020;
  localparam cfid_t F_RD_STATE  = 10'd1021;
  localparam cfid_t F_WR_STATUS = 10'd1022;
  localparam cfid_t F_RD_STATUS = 10'd1023;

  if (CXU_FUNC_ID_W != $bits(cfid_t)) begin : g_bad_func_w
    $error("CXU_FUNC_ID_W must equal the cfid_t width");
  end
  if (CXU_N_STATES < 1) begin : g_bad_n_states
    $error("CXU_N_STATES must be at least 1");
  end

  typedef struct packed {
    logic                      vld;
    cfid_t                     func;
    logic [CXU_STATE_ID_W-1:0] state;
    logic [DW-1:0]             d0;
    logic [AW-1:0]             prod;
  } stage_t;

  stage_t req_s, out_s;
  logic signed [AW-1:0] prod_in;

  assign prod_in = $signed(req_data0) * $signed(req_data1);

  always_comb begin
    req_s.vld   = req_valid;
    req_s.func  = req_func;
    req_s.state = req_state;
    req_s.d0    = req_data0;
    req_s.prod  = prod_in;
  end

  if (CXU_LATENCY == 0) begin : g_comb
    assign out_s = req_s;
  end else begin : g_pipe
    stage_t pipe_q [CXU_LATENCY];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < CXU_LATENCY; i++) pipe_q[i].vld <= 1'b0;
      end else if (clk_en) begin
        pipe_q[0] <= req_s;
        for (int unsigned i = 1; i < CXU_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign out_s = pipe_q[CXU_LATENCY-1];
  end

  logic [AW-1:0]         acc_mem [CXU_N_STATES];
  cs_e                   css_q   [CXU_N_STATES];
  logic [CXU_N_STATES-1:0] zacc_q, widx_q;

  logic [SIDX_W-1:0] sidx;
  logic [AW-1:0]     acc_rd, acc_d, sum, diff;
  cs_e               cs_rd;
  cxu_status_t       status_d;
  logic [DW-1:0]     data_d;
  logic              wr_acc, wr_en, sat_rd, known;
`ifdef MULACC_WIDE_CXU_SAT_EN
  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  logic sat_hit;
`endif

  assign sidx = (out_s.state < CXU_STATE_ID_W'(CXU_N_STATES)) ? out_s.state[SIDX_W-1:0] : '0;

  always_comb begin
    acc_rd   = zacc_q[sidx] ? '0 : acc_mem[sidx];
    cs_rd    = css_q[sidx];
    sum      = acc_rd + out_s.prod;
    diff     = acc_rd - out_s.prod;
    acc_d    = acc_rd;
    wr_acc   = 1'b0;
    data_d   = '0;
    known    = (out_s.func <= F_CLEAR) || (out_s.func >= F_WR_STATE);
`ifdef MULACC_WIDE_CXU_SAT_EN
    sat_hit  = 1'b0;
`endif
    if (!out_s.vld)                                  status_d = CXU_OK;
    else if (out_s.state >= CXU_STATE_ID_W'(CXU_N_STATES)) status_d = CXU_ERROR_STATE;
    else if (cs_rd == CS_OFF && out_s.func != F_RD_STATUS && out_s.func != F_WR_STATUS)
                                                     status_d = CXU_ERROR_OFF;
    else if (!known)                                 status_d = CXU_ERROR_FUNC;
    else                                             status_d = CXU_OK;

    // read_hi rewrites the accumulator it read so that clearing zacc never exposes stale RAM
    case (out_s.func)
      F_MUL:    begin acc_d = out_s.prod; wr_acc = 1'b1; end
      F_MULACC: begin
        acc_d = sum; wr_acc = 1'b1;
`ifdef MULACC_WIDE_CXU_SAT_EN
        if (acc_rd[AW-1] == out_s.prod[AW-1] && sum[AW-1] != acc_rd[AW-1]) begin
          acc_d = acc_rd[AW-1] ? ACC_MIN : ACC_MAX; sat_hit = 1'b1;
        end
`endif
      end
      F_MULSUB: begin
        acc_d = diff; wr_acc = 1'b1;
`ifdef MULACC_WIDE_CXU_SAT_EN
        if (acc_rd[AW-1] != out_s.prod[AW-1] && diff[AW-1] != acc_rd[AW-1]) begin
          acc_d = acc_rd[AW-1] ? ACC_MIN : ACC_MAX; sat_hit = 1'b1;
        end
`endif
      end
      F_RD_HI:  wr_acc = 1'b1;
      F_CLEAR:  begin acc_d = '0; wr_acc = 1'b1; end
      F_WR_STATE: begin
        wr_acc = 1'b1;
        if (widx_q[sidx]) acc_d[AW-1:DW] = out_s.d0;
        else              acc_d[DW-1:0]  = out_s.d0;
      end
      default: ;
    endcase

    case (out_s.func)
      F_MUL, F_MULACC, F_MULSUB, F_CLEAR: data_d = acc_d[DW-1:0];
      F_RD_HI:     data_d = acc_rd[AW-1:DW];
      F_RD_STATE:  data_d = widx_q[sidx] ? acc_rd[AW-1:DW] : acc_rd[DW-1:0];
      F_RD_STATUS: data_d = {sat_rd, {(DW-13){1'b0}}, 10'd2, cs_rd};
      default:     data_d = '0;
    endcase
    if (!out_s.vld || status_d != CXU_OK) data_d = '0;
  end

  assign wr_en       = clk_en && out_s.vld && (status_d == CXU_OK);
  assign resp_valid  = out_s.vld;
  assign resp_status = status_d;
  assign resp_data   = data_d;

  always_ff @(posedge clk) begin
    if (!rst && wr_en && wr_acc) acc_mem[sidx] <= acc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CXU_N_STATES; i++) begin
        css_q[i]  <= CS_INIT;
        zacc_q[i] <= 1'b1;
        widx_q[i] <= 1'b0;
      end
    end else if (wr_en) begin
      case (out_s.func)
        F_MUL, F_MULACC, F_MULSUB, F_RD_HI, F_CLEAR: begin
          css_q[sidx]  <= CS_DIRTY;
          zacc_q[sidx] <= 1'b0;
        end
        F_WR_STATE: begin
          css_q[sidx]  <= CS_DIRTY;
          zacc_q[sidx] <= 1'b0;
          widx_q[sidx] <= ~widx_q[sidx];
        end
        F_RD_STATE: widx_q[sidx] <= ~widx_q[sidx];
        F_WR_STATUS: begin
          css_q[sidx]  <= cs_e'(out_s.d0[1:0]);
          widx_q[sidx] <= 1'b0;
          if (out_s.d0[1:0] == CS_OFF || out_s.d0[1:0] == CS_INIT) zacc_q[sidx] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MULACC_WIDE_CXU_SAT_EN
  logic [CXU_N_STATES-1:0] sat_q;
  always_ff @(posedge clk) begin
    if (rst) sat_q <= '0;
    else if (wr_en) begin
      if (out_s.func == F_WR_STATUS) sat_q[sidx] <= 1'b0;
      else if (sat_hit)              sat_q[sidx] <= 1'b1;
    end
  end
  assign sat_rd = sat_q[sidx];
`else
  assign sat_rd = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{req_cxu, (CXU_RESET != 0)};
endmodule

// File: tb/tb_mulacc_wide_cxu.sv
// Randomized self-checking bench for mulacc_wide_cxu against a per-context arithmetic model.
// Honors MULACC_WIDE_CXU_SAT_EN the same way as the design.
module tb_mulacc_wide_cxu;
  localparam int LAT = 2;
  localparam logic [2:0] ST_OK = 3'd0, ST_FUNC = 3'd1, ST_STATE = 3'd2, ST_OFF = 3'd3;

  logic        clk = 1'b0, rst = 1'b1, clk_en = 1'b1, req_valid = 1'b0;
  logic [0:0]  req_cxu = 1'b0;
  logic [2:0]  req_state = '0;
  logic [9:0]  req_func = '0;
  logic [31:0] req_data0 = '0, req_data1 = '0;
  logic        resp_valid;
  logic [2:0]  resp_status;
  logic [31:0] resp_data;

  mulacc_wide_cxu #(.CXU_LATENCY(LAT), .CXU_N_STATES(4), .CXU_DATA_W(32)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req_valid(req_valid), .req_cxu(req_cxu),
    .req_state(req_state), .req_func(req_func), .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(resp_valid), .resp_status(resp_status), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // reference model: value of each accumulator, context status, word index, sticky saturation
  logic [63:0] m_acc [4];
  logic [1:0]  m_cs  [4];
  bit          m_widx[4];
  bit          m_sat [4];

  function automatic void mdl_reset();
    for (int i = 0; i < 4; i++) begin
      m_acc[i] = '0; m_cs[i] = 2'd1; m_widx[i] = 1'b0; m_sat[i] = 1'b0;
    end
  endfunction

`ifdef MULACC_WIDE_CXU_SAT_EN
  localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] SMIN = 66'sh3_8000_0000_0000_0000;
`endif

  function automatic logic [63:0] fit(input logic signed [65:0] w, output bit hit);
    hit = 1'b0;
`ifdef MULACC_WIDE_CXU_SAT_EN
    if (w > SMAX) begin hit = 1'b1; return 64'h7FFF_FFFF_FFFF_FFFF; end
    if (w < SMIN) begin hit = 1'b1; return 64'h8000_0000_0000_0000; end
`endif
    return w[63:0];
  endfunction

  function automatic void mdl(input logic [2:0] s, input logic [9:0] f, input logic [31:0] a,
                              input logic [31:0] b, output logic [2:0] st, output logic [31:0] d);
    logic signed [63:0] sa, sb, p;
    logic signed [65:0] w;
    logic [63:0] r;
    bit hit;
    st = ST_OK; d = '0;
    if (s >= 3'd4) begin st = ST_STATE; return; end
    if (m_cs[s] == 2'd0 && f != 10'd1022 && f != 10'd1023) begin st = ST_OFF; return; end
    sa = $signed(a); sb = $signed(b); p = sa * sb;
    case (f)
      10'd0, 10'd1, 10'd2, 10'd4: begin
        hit = 1'b0;
        if (f == 10'd0)      r = p;
        else if (f == 10'd4) r = '0;
        else begin
          w = (f == 10'd1) ? $signed(m_acc[s]) + p : $signed(m_acc[s]) - p;
          r = fit(w, hit);
        end
        if (hit) m_sat[s] = 1'b1;
        m_acc[s] = r; m_cs[s] = 2'd3; d = r[31:0];
      end
      10'd3: begin d = m_acc[s][63:32]; m_cs[s] = 2'd3; end
      10'd1020: begin
        if (m_widx[s]) m_acc[s][63:32] = a; else m_acc[s][31:0] = a;
        m_widx[s] = ~m_widx[s]; m_cs[s] = 2'd3;
      end
      10'd1021: begin
        d = m_widx[s] ? m_acc[s][63:32] : m_acc[s][31:0];
        m_widx[s] = ~m_widx[s];
      end
      10'd1022: begin
        m_cs[s] = a[1:0]; m_widx[s] = 1'b0; m_sat[s] = 1'b0;
        if (a[1:0] <= 2'd1) m_acc[s] = '0;
      end
      10'd1023: d = (32'(m_sat[s]) << 31) | (32'd2 << 2) | 32'(m_cs[s]);
      default: st = ST_FUNC;
    endcase
  endfunction

  typedef struct {
    bit          vld;
    logic [2:0]  st;
    logic [31:0] d;
    bit          hk;
    logic [31:0] k;
    string       tag;
  } exp_t;

  exp_t q[$];
  exp_t last;
  bit   en_prev = 1'b1;

  function automatic exp_t none();
    exp_t e;
    e.vld = 1'b0; e.st = ST_OK; e.d = '0; e.hk = 1'b0; e.k = '0; e.tag = "idle";
    return e;
  endfunction

  // entered and left at a negedge: check what the DUT shows now, then drive the next cycle
  task automatic step(input bit en, input bit v, input logic [2:0] s, input logic [9:0] f,
                      input logic [31:0] a, input logic [31:0] b, input bit hk,
                      input logic [31:0] k, input string tag);
    exp_t e;
    if (en_prev) last = (q.size() == LAT) ? q.pop_front() : none();
    chk({last.tag, ".valid"}, 64'(resp_valid), 64'(last.vld));
    chk({last.tag, ".status"}, 64'(resp_status), 64'(last.st));
    if (last.vld) chk({last.tag, ".data"}, 64'(resp_data), 64'(last.d));
    if (last.hk)  chk({last.tag, ".plan"}, 64'(resp_data), 64'(last.k));
    clk_en = en; req_valid = v; req_state = s; req_func = f; req_data0 = a; req_data1 = b;
    if (en) begin
      e = none();
      e.vld = v; e.tag = tag;
      if (v) begin
        mdl(s, f, a, b, e.st, e.d);
        e.hk = hk; e.k = k;
      end
      q.push_back(e);
    end
    en_prev = en;
    @(negedge clk);
  endtask

  task automatic rq(input logic [2:0] s, input logic [9:0] f, input logic [31:0] a,
                    input logic [31:0] b, input string tag);
    step(1'b1, 1'b1, s, f, a, b, 1'b0, '0, tag);
  endtask

  task automatic rk(input logic [2:0] s, input logic [9:0] f, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] k, input string tag);
    step(1'b1, 1'b1, s, f, a, b, 1'b1, k, tag);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 3'd0, 10'd0, '0, '0, 1'b0, '0, "idle");
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 4))
      0:       return 32'($urandom_range(0, 15));
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  s;
    logic [9:0]  f;
    logic [31:0] a;
    mdl_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    rk(3'd0, 10'd1023, '0, '0, 32'h0000_0009, "rst_status");
    rk(3'd0, 10'd1021, '0, '0, 32'h0, "rst_rd0");
    rk(3'd0, 10'd1021, '0, '0, 32'h0, "rst_rd1");

    rk(3'd1, 10'd0, 32'h0001_0000, 32'h0001_0000, 32'h0, "mul_lo");
    rk(3'd1, 10'd3, '0, '0, 32'h1, "mul_hi");
    rk(3'd1, 10'd1023, '0, '0, 32'h0000_000B, "mul_cs");

    rk(3'd0, 10'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, "mul_neg");
    rk(3'd0, 10'd1, 32'd2, 32'd4, 32'hFFFF_FFF9, "macc_b2b");
    rk(3'd0, 10'd3, '0, '0, 32'hFFFF_FFFF, "macc_hi");
    rk(3'd0, 10'd2, 32'd3, 32'd3, 32'hFFFF_FFF0, "msub");

    rq(3'd2, 10'd1022, 32'd3, '0, "wst_dirty");
    rq(3'd2, 10'd1020, 32'hAAAA_5555, '0, "wstate0");
    rq(3'd2, 10'd1020, 32'h1234_5678, '0, "wstate1");
    rk(3'd2, 10'd1021, '0, '0, 32'hAAAA_5555, "rstate0");
    rk(3'd2, 10'd1021, '0, '0, 32'h1234_5678, "rstate1");
    rq(3'd2, 10'd1022, 32'd0, '0, "wst_off");
    rq(3'd2, 10'd1, 32'd1, 32'd1, "off_macc");
    rq(3'd2, 10'd1022, 32'd1, '0, "wst_init");
    rk(3'd2, 10'd1021, '0, '0, 32'h0, "init_rd");

    rq(3'd4, 10'd0, 32'd9, 32'd9, "bad_state");
    rq(3'd7, 10'd1022, 32'd0, '0, "bad_state7");
    rq(3'd0, 10'd7, 32'd9, 32'd9, "bad_func");
    rk(3'd0, 10'd3, '0, '0, 32'hFFFF_FFFF, "after_err");

    rq(3'd3, 10'd1022, 32'd3, '0, "sat_prep");
    rq(3'd3, 10'd1020, 32'hFFFF_FFFF, '0, "sat_lo");
    rq(3'd3, 10'd1020, 32'h7FFF_FFFF, '0, "sat_hi");
`ifdef MULACC_WIDE_CXU_SAT_EN
    rk(3'd3, 10'd1, 32'd1, 32'd1, 32'hFFFF_FFFF, "sat_macc");
    rk(3'd3, 10'd3, '0, '0, 32'h7FFF_FFFF, "sat_rdhi");
    rk(3'd3, 10'd1023, '0, '0, 32'h8000_000B, "sat_flag");
`else
    rk(3'd3, 10'd1, 32'd1, 32'd1, 32'h0000_0000, "wrap_macc");
    rk(3'd3, 10'd3, '0, '0, 32'h8000_0000, "wrap_rdhi");
    rk(3'd3, 10'd1023, '0, '0, 32'h0000_000B, "wrap_flag");
`endif

    // reset with two requests in flight: neither may respond or update state
    rq(3'd0, 10'd1, 32'h1234, 32'h5678, "drop0");
    rst = 1'b1; clk_en = 1'b1;
    req_valid = 1'b1; req_state = 3'd1; req_func = 10'd0; req_data0 = 32'd7; req_data1 = 32'd7;
    @(negedge clk);
    chk("rst_drop.valid", 64'(resp_valid), 64'd0);
    chk("rst_drop.status", 64'(resp_status), 64'(ST_OK));
    rst = 1'b0; req_valid = 1'b0;
    q.delete(); mdl_reset(); last = none(); en_prev = 1'b1;
    for (int i = 0; i < 4; i++) rk(3'(i), 10'd1023, '0, '0, 32'h0000_0009, "post_rst_cs");
    rk(3'd0, 10'd1021, '0, '0, 32'h0, "post_rst_acc");

    for (int n = 0; n < 600; n++) begin
      s = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      case ($urandom_range(0, 12))
        0, 1:    f = 10'd1;
        2:       f = 10'd2;
        3:       f = 10'd0;
        4:       f = 10'd3;
        5:       f = 10'd4;
        6:       f = 10'd1020;
        7, 8:    f = 10'd1021;
        9:       f = 10'd1022;
        10:      f = 10'd1023;
        11:      f = 10'($urandom_range(5, 1019));
        default: f = 10'd1;
      endcase
      a = rnd_word();
      if (f == 10'd1022) a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : 32'd3;
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) != 0), s, f, a, rnd_word(),
           1'b0, '0, "rnd");
    end
    repeat (LAT + 1) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
